// File: rtl/sa_pkg.sv
// Shared systolic-array constants and the per-lane skew depth helper,
// used by both the input skew line and the output deskew block.
package sa_pkg;

    localparam int SA_LANES     = 4;
    localparam int SA_DAT_WIDTH = 16;
    localparam int SA_CNT_WIDTH = 16;

    // Lane i trails lane 0 by i cycles, so it needs LANES-1-i cycles of delay to realign.
    function automatic int lane_dly(input int lane, input int lanes);
        return lanes - 1 - lane;
    endfunction

endpackage

// File: rtl/sa_lane_dly.sv
// Fixed-depth delay line carrying one lane's valid and data together.
// DEPTH=0 degenerates to plain wires.
module sa_lane_dly
    import sa_pkg::*;
#(
    parameter int DEPTH     = 1,
    parameter int DAT_WIDTH = SA_DAT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_vld,
    input  logic [DAT_WIDTH-1:0] i_dat,
    output logic                 o_vld,
    output logic [DAT_WIDTH-1:0] o_dat
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctl;
            assign unused_ctl = clk ^ rst;
            assign o_vld      = i_vld;
            assign o_dat      = i_dat;
        end else begin : g_pipe
            logic [DEPTH-1:0]     vld_q;
            logic [DAT_WIDTH-1:0] dat_q [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= '0;
                    for (int k = 0; k < DEPTH; k++) begin
                        dat_q[k] <= '0;
                    end
                end else begin
                    vld_q[0] <= i_vld;
                    dat_q[0] <= i_dat;
                    for (int k = 1; k < DEPTH; k++) begin
                        vld_q[k] <= vld_q[k-1];
                        dat_q[k] <= dat_q[k-1];
                    end
                end
            end

            assign o_vld = vld_q[DEPTH-1];
            assign o_dat = dat_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/sa_deskew.sv
// Realigns the skewed systolic-array result lanes into one vector with a single
// valid, counting good vectors and flagging any break in the skew pattern.
module sa_deskew
    import sa_pkg::*;
#(
    parameter int LANES     = SA_LANES,
    parameter int DAT_WIDTH = SA_DAT_WIDTH,
    parameter int CNT_WIDTH = SA_CNT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LANES-1:0]           i_dat_vld,
    input  logic [LANES*DAT_WIDTH-1:0] i_dat,
    input  logic                       i_clr,
    output logic                       o_dat_vld,
    output logic [LANES*DAT_WIDTH-1:0] o_dat,
    output logic                       o_err,
    output logic [CNT_WIDTH-1:0]       o_vec_cnt
);

    logic [LANES-1:0]           av;
    logic [LANES*DAT_WIDTH-1:0] aligned;
    logic                       all_vld;
    logic                       mismatch;

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            sa_lane_dly #(
                .DEPTH     (lane_dly(g, LANES)),
                .DAT_WIDTH (DAT_WIDTH)
            ) u_dly (
                .clk   (clk),
                .rst   (rst),
                .i_vld (i_dat_vld[g]),
                .i_dat (i_dat[g*DAT_WIDTH +: DAT_WIDTH]),
                .o_vld (av[g]),
                .o_dat (aligned[g*DAT_WIDTH +: DAT_WIDTH])
            );
        end
    endgenerate

    assign all_vld  = &av;
    assign mismatch = (|av) & ~all_vld;

    // A partial vector is never emitted; it only raises the sticky error, which beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_dat_vld <= 1'b0;
            o_dat     <= '0;
            o_err     <= 1'b0;
            o_vec_cnt <= '0;
        end else begin
            o_dat_vld <= all_vld;
            if (all_vld) begin
                o_dat <= aligned;
            end

            if (mismatch) begin
                o_err <= 1'b1;
            end else if (i_clr) begin
                o_err <= 1'b0;
            end

            if (i_clr) begin
                o_vec_cnt <= '0;
            end else if (all_vld) begin
                o_vec_cnt <= o_vec_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule
